// File: rtl/spi_flash_stream_reader_pkg.sv
// spi_flash_stream_reader_pkg
//   Shared constants and types for the SPI flash stream reader.
//   READ_OPCODE : default single-bit READ command byte
//   SPI_ADDR_W  : flash byte-address width
//   TX_BITS     : command + address bits shifted out before the data phase
//   state_t     : transaction FSM states
package spi_flash_stream_reader_pkg;

  localparam logic [7:0] READ_OPCODE = 8'h03;
  localparam int         SPI_ADDR_W  = 24;
  localparam int         TX_BITS     = 8 + SPI_ADDR_W;
  localparam int         TX_CNT_W    = $clog2(TX_BITS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT_OUT = 2'd1,
    ST_SHIFT_IN  = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

endpackage

// File: rtl/spi_flash_stream_reader_if.sv
// spi_flash_stream_reader_if
//   SPI pin bundle between the stream reader (master) and the flash side (slave).
//   spi_cs   : active-high chip select
//   spi_sclk : SPI clock, mode 0
//   spi_out0 : io[0] driven by the master (MOSI)
//   spi_dir0 : io[0] direction, 0 = output, 1 = input
//   spi_miso : io[1] driven by the flash
interface spi_flash_stream_reader_if;

  logic spi_cs;
  logic spi_sclk;
  logic spi_out0;
  logic spi_dir0;
  logic spi_miso;

  modport master (
    output spi_cs,
    output spi_sclk,
    output spi_out0,
    output spi_dir0,
    input  spi_miso
  );

  modport slave (
    input  spi_cs,
    input  spi_sclk,
    input  spi_out0,
    input  spi_dir0,
    output spi_miso
  );

endinterface

// File: rtl/spi_flash_stream_reader.sv
// spi_flash_stream_reader
//   Single-bit SPI READ master. An accepted start shifts out {CMD_READ, addr}
//   MSB first, then shifts in len bytes, each presented as a one-cycle
//   data_valid strobe. SCLK runs at clk/2; every output is registered.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, addr, len  : request (sampled only in IDLE)
//   abort             : terminate the current transaction
//   busy, done        : transaction status
//   data, data_valid  : received byte stream
//   spi               : SPI pin bundle (master side)
module spi_flash_stream_reader
  import spi_flash_stream_reader_pkg::*;
#(
  parameter int         LEN_W    = 8,
  parameter logic [7:0] CMD_READ = READ_OPCODE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SPI_ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]      len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            data,
  output logic                  data_valid,
  spi_flash_stream_reader_if.master spi
);

  localparam logic [LEN_W-1:0]    LEN_ONE = LEN_W'(1);
  localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(TX_BITS - 1);

  state_t                state_reg, state_next;
  logic [TX_BITS-1:0]    tx_reg, tx_next;
  logic [TX_CNT_W-1:0]   tx_cnt_reg, tx_cnt_next;
  logic [7:0]            rx_reg, rx_next;
  logic [2:0]            bit_cnt_reg, bit_cnt_next;
  logic [LEN_W-1:0]      byte_cnt_reg, byte_cnt_next;
  logic [LEN_W-1:0]      len_reg, len_next;
  logic [7:0]            data_reg, data_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;
  logic                  cs_reg, cs_next;
  logic                  sclk_reg, sclk_next;
  logic                  out0_reg, out0_next;
  logic                  dir0_reg, dir0_next;

  logic accept;
  logic last_byte;

  // abort has priority over a simultaneous start in IDLE
  assign accept    = start & ~abort;
  assign last_byte = (byte_cnt_reg == len_reg - LEN_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      tx_reg         <= '0;
      tx_cnt_reg     <= '0;
      rx_reg         <= '0;
      bit_cnt_reg    <= '0;
      byte_cnt_reg   <= '0;
      len_reg        <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      cs_reg         <= 1'b0;
      sclk_reg       <= 1'b0;
      out0_reg       <= 1'b0;
      dir0_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tx_reg         <= tx_next;
      tx_cnt_reg     <= tx_cnt_next;
      rx_reg         <= rx_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      len_reg        <= len_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      cs_reg         <= cs_next;
      sclk_reg       <= sclk_next;
      out0_reg       <= out0_next;
      dir0_reg       <= dir0_next;
    end
  end

  // sclk_reg high means the coming edge is a falling SCLK edge: that is where
  // the next tx bit is launched and where MISO is sampled.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = (len == '0) ? ST_GAP : ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (abort)                                 state_next = ST_GAP;
        else if (sclk_reg && tx_cnt_reg == TX_LAST) state_next = ST_SHIFT_IN;
      end
      ST_SHIFT_IN: begin
        if (abort)                                             state_next = ST_GAP;
        else if (sclk_reg && bit_cnt_reg == 3'd7 && last_byte) state_next = ST_GAP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_next         = tx_reg;
    tx_cnt_next     = tx_cnt_reg;
    rx_next         = rx_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    len_next        = len_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    done_next       = 1'b0;
    cs_next         = cs_reg;
    sclk_next       = sclk_reg;
    out0_next       = out0_reg;
    dir0_next       = dir0_reg;
    busy_next       = (state_next != ST_IDLE);
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          len_next      = len;
          tx_next       = {CMD_READ, addr};
          tx_cnt_next   = '0;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          if (len == '0) begin
            // zero-length request completes without touching the bus
            done_next = 1'b1;
          end else begin
            cs_next   = 1'b1;
            sclk_next = 1'b0;
            out0_next = CMD_READ[7];
            dir0_next = 1'b0;
          end
        end
      end
      ST_SHIFT_OUT: begin
        if (abort) begin
          cs_next   = 1'b0;
          sclk_next = 1'b0;
          dir0_next = 1'b0;
          out0_next = 1'b0;
        end else begin
          sclk_next = ~sclk_reg;
          if (sclk_reg) begin
            if (tx_cnt_reg == TX_LAST) begin
              // hand io[0] over to the flash for the data phase
              dir0_next = 1'b1;
              out0_next = 1'b0;
            end else begin
              tx_cnt_next = tx_cnt_reg + 1'b1;
              tx_next     = {tx_reg[TX_BITS-2:0], 1'b0};
              out0_next   = tx_reg[TX_BITS-2];
            end
          end
        end
      end
      ST_SHIFT_IN: begin
        if (abort) begin
          // a partial or just-completed byte is dropped
          cs_next   = 1'b0;
          sclk_next = 1'b0;
          dir0_next = 1'b0;
          out0_next = 1'b0;
        end else begin
          sclk_next = ~sclk_reg;
          if (sclk_reg) begin
            rx_next      = {rx_reg[6:0], spi.spi_miso};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              data_next       = {rx_reg[6:0], spi.spi_miso};
              data_valid_next = 1'b1;
              byte_cnt_next   = byte_cnt_reg + LEN_ONE;
              if (last_byte) begin
                done_next = 1'b1;
                cs_next   = 1'b0;
                sclk_next = 1'b0;
                dir0_next = 1'b0;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign data         = data_reg;
  assign data_valid   = data_valid_reg;
  assign spi.spi_cs   = cs_reg;
  assign spi.spi_sclk = sclk_reg;
  assign spi.spi_out0 = out0_reg;
  assign spi.spi_dir0 = dir0_reg;

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// tb_spi_flash_stream_reader
//   Self-checking bench: a mode-0 flash model answers READ with
//   byte = addr[7:0] + offset; directed table vectors, randomized
//   transactions against an arithmetic reference model, and an
//   asynchronous reset sequence.
module tb_spi_flash_stream_reader;

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          abort_at;
    int          start_x1;
    int          start_x2;
    int          exp_nvalid;
    int          exp_done;
    int          exp_cs_cnt;
    int          exp_busy_end;
    int          exp_mosi_n;
  } vec_t;

  typedef struct {
    int          n_valid;
    int          done_edge;
    int          cs_cnt;
    int          busy_end;
    int          mosi_n;
    logic [31:0] mosi;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [7:0]  data;
  logic        data_valid;

  spi_flash_stream_reader_if spi_bus ();

  spi_flash_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .data       (data),
    .data_valid (data_valid),
    .spi        (spi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass;
  int   n_total;
  int   txn_no;
  logic prev_dv;
  vec_t tbl [10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Mode-0 flash: captures 32 command/address bits on rising SCLK, then
  // presents data bits MSB first on each falling SCLK.
  initial begin
    logic        cs_q, sclk_q;
    int          bits, obits;
    logic [31:0] sr;
    logic [7:0]  b;
    cs_q = 1'b0; sclk_q = 1'b0; bits = 0; obits = 0; sr = '0; b = '0;
    spi_bus.spi_miso = 1'b0;
    forever begin
      @(spi_bus.spi_cs or spi_bus.spi_sclk);
      if (spi_bus.spi_cs && !cs_q) begin
        bits  = 0;
        obits = 0;
      end
      if (spi_bus.spi_cs && spi_bus.spi_sclk && !sclk_q && bits < 32) begin
        sr = {sr[30:0], spi_bus.spi_out0};
        bits++;
      end
      if (spi_bus.spi_cs && !spi_bus.spi_sclk && sclk_q && bits == 32) begin
        b = sr[7:0] + 8'(obits / 8);
        spi_bus.spi_miso = b[7 - (obits % 8)];
        obits++;
      end
      cs_q   = spi_bus.spi_cs;
      sclk_q = spi_bus.spi_sclk;
    end
  end

  // One clock: sample after the rising edge, on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (rst_n) begin
      chk("sclk_only_with_cs", longint'(spi_bus.spi_sclk & ~spi_bus.spi_cs), 0);
      chk("dir0_only_with_cs", longint'(spi_bus.spi_dir0 & ~spi_bus.spi_cs), 0);
      chk("dv_back_to_back", longint'(data_valid & prev_dv), 0);
    end
    prev_dv = data_valid;
  endtask

  // Reference model: timing follows from edge arithmetic alone.
  function automatic vec_t model(input logic [23:0] a, input int l, input int ab);
    vec_t m;
    int   nat, fin, en;
    bit   aborted;
    m.addr = a; m.len = l; m.abort_at = ab; m.start_x1 = -1; m.start_x2 = -1;
    nat     = (l == 0) ? 0 : 80 + 16 * (l - 1);
    aborted = (ab >= 1 && ab <= nat);
    fin     = aborted ? ab : nat;
    m.exp_nvalid = 0;
    for (int n = 0; n < l; n++) begin
      en = 80 + 16 * n;
      if (en < fin || (en == fin && !aborted)) m.exp_nvalid++;
    end
    m.exp_done     = aborted ? -1 : fin;
    m.exp_cs_cnt   = fin;
    m.exp_busy_end = fin + 1;
    m.exp_mosi_n   = (fin / 2 > 32) ? 32 : fin / 2;
    return m;
  endfunction

  task automatic run_txn(input vec_t v, output obs_t o);
    int          e, nv, mosi_n;
    logic [31:0] mosi;
    o = '{default: 0};
    o.done_edge = -1;
    o.busy_end  = -1;
    e = 0; nv = 0; mosi_n = 0; mosi = '0;
    addr  = v.addr;
    len   = 8'(v.len);
    start = 1'b1;
    abort = 1'b0;
    forever begin
      tick();
      if (data_valid) begin
        chk("dv_edge", e, 80 + 16 * nv);
        chk("dv_byte", data, longint'(8'(v.addr[7:0] + 8'(nv))));
        nv++;
      end
      if (done) begin
        chk("done_once", o.done_edge, -1);
        o.done_edge = e;
      end
      if (spi_bus.spi_cs) o.cs_cnt++;
      if (spi_bus.spi_cs && spi_bus.spi_sclk && !spi_bus.spi_dir0 && mosi_n < 32) begin
        mosi = {mosi[30:0], spi_bus.spi_out0};
        mosi_n++;
      end
      chk("dir0_data_phase_only", longint'(spi_bus.spi_dir0 && e < 64), 0);
      if (e == 0) chk("busy_after_accept", busy, 1);
      if (!busy) begin
        o.busy_end = e;
        break;
      end
      if (e >= 6000) begin
        chk("txn_timeout_busy", busy, 0);
        break;
      end
      e++;
      start = (e == v.start_x1 || e == v.start_x2);
      addr  = start ? ~v.addr : v.addr;
      abort = (e == v.abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    o.n_valid = nv;
    o.mosi_n  = mosi_n;
    o.mosi    = mosi;
  endtask

  task automatic compare(input vec_t v, input obs_t o);
    logic [31:0] word;
    longint      exp_mosi;
    word     = {8'h03, v.addr};
    exp_mosi = (v.exp_mosi_n == 0) ? 0 : longint'(word >> (32 - v.exp_mosi_n));
    chk("n_valid", o.n_valid, v.exp_nvalid);
    chk("done_edge", o.done_edge, v.exp_done);
    chk("cs_cycles", o.cs_cnt, v.exp_cs_cnt);
    chk("busy_end", o.busy_end, v.exp_busy_end);
    chk("mosi_bits", o.mosi_n, v.exp_mosi_n);
    chk("mosi_value", o.mosi, exp_mosi);
    $display("txn %0d: addr=%06h len=%0d abort_at=%0d valid=%0d done_edge=%0d busy_end=%0d",
             txn_no, v.addr, v.len, v.abort_at, o.n_valid, o.done_edge, o.busy_end);
    txn_no++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t o;
    vec_t v;
    int   nat, l, ab;
    logic [23:0] a;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; addr = '0; len = '0;
    prev_dv = 1'b0; n_pass = 0; n_total = 0; txn_no = 0;

    //            addr        len  abort sx1 sx2  nval done  cs   bend  mosi
    tbl[0] = '{24'h012345,   4,  -1,  -1, -1,   4,  128, 128,  129, 32};
    tbl[1] = '{24'h0ABCDE,   0,  -1,  -1, -1,   0,    0,   0,    1,  0};
    tbl[2] = '{24'h012345,   4,  70,  -1, -1,   0,   -1,  70,   71, 32};
    tbl[3] = '{24'h0000F0,   4,  96,  -1, -1,   1,   -1,  96,   97, 32};
    tbl[4] = '{24'h100200,   2,  -1,  10, 40,   2,   96,  96,   97, 32};
    tbl[5] = '{24'hFFFFFF,   1,  -1,  -1, -1,   1,   80,  80,   81, 32};
    tbl[6] = '{24'hABCDEF,   3,  20,  -1, -1,   0,   -1,  20,   21, 10};
    tbl[7] = '{24'h00AA55,   2,  80,  -1, -1,   0,   -1,  80,   81, 32};
    tbl[8] = '{24'h123456,   2,   1,  -1, -1,   0,   -1,   1,    2,  0};
    tbl[9] = '{24'h0000FE, 255,  -1,  -1, -1, 255, 4144, 4144, 4145, 32};

    repeat (3) @(negedge clk);
    chk("reset_outputs", longint'({busy, done, data, data_valid, spi_bus.spi_cs,
                                   spi_bus.spi_sclk, spi_bus.spi_out0, spi_bus.spi_dir0}), 0);
    rst_n = 1'b1;
    // abort together with start in IDLE must not start anything
    start = 1'b1; abort = 1'b1; addr = 24'h000100; len = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_with_abort_busy", busy, 0);
    chk("start_with_abort_cs", spi_bus.spi_cs, 0);
    tick();

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], o);
      compare(tbl[i], o);
    end

    for (int i = 0; i < 24; i++) begin
      a   = 24'($urandom);
      l   = int'($urandom_range(0, 6));
      nat = (l == 0) ? 0 : 80 + 16 * (l - 1);
      ab  = (l > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, nat)) : -1;
      v   = model(a, l, ab);
      run_txn(v, o);
      compare(v, o);
    end

    // asynchronous reset in the middle of the data phase
    addr = 24'h000010; len = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (90) tick();
    chk("pre_reset_in_data_phase", spi_bus.spi_dir0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", longint'({busy, done, data, data_valid, spi_bus.spi_cs,
                                         spi_bus.spi_sclk, spi_bus.spi_out0, spi_bus.spi_dir0}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_dv = 1'b0;
    tick();
    run_txn(tbl[0], o);
    compare(tbl[0], o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
